// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared types and constants for the PDM microphone front end
//
// Purpose: FSM state type, smallest legal half-period, and the channel tag
// reused by the stereo filter wrappers downstream.
package pdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pdm_state_t;

  // Smallest half-period that keeps left and right strobes apart.
  localparam int MIN_DIVIDER = 2;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_t;

endpackage

// File: rtl/pdm_clock_divider.sv
// rtl/pdm_clock_divider.sv - half-period counter generating the microphone clock
//
// Purpose: counts div_q cycles per half period, toggles pdm_clk_o, and flags
// the cycle before each edge so captures land on the same clk_i edge as the
// toggle. div_q is reloaded only at rising edges (full-period boundary).
// Ports:
//   clk_i, rst_i  system clock, synchronous active-high reset
//   run_i         counter enabled (FSM not idle)
//   load_i        start of a session: take divider_i, restart the count
//   divider_i     requested half-period in clk_i cycles
//   pdm_clk_o     microphone clock
//   rise_evt_o    pdm_clk_o rises on the next edge
//   fall_evt_o    pdm_clk_o falls on the next edge
//   cnt_zero_o    counter is at the start of a half period
module pdm_clock_divider #(
  parameter int DIVIDER_WIDTH = 16,
  parameter int MIN_DIV       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     run_i,
  input  logic                     load_i,
  input  logic [DIVIDER_WIDTH-1:0] divider_i,
  output logic                     pdm_clk_o,
  output logic                     rise_evt_o,
  output logic                     fall_evt_o,
  output logic                     cnt_zero_o
);

  logic [DIVIDER_WIDTH-1:0] div_q;
  logic [DIVIDER_WIDTH-1:0] cnt;
  logic                     wrap;
  logic                     reload_ok;

  assign wrap       = run_i && (cnt == div_q - DIVIDER_WIDTH'(1));
  assign rise_evt_o = wrap && !pdm_clk_o;
  assign fall_evt_o = wrap && pdm_clk_o;
  assign cnt_zero_o = (cnt == '0);
  // A too-small divider arriving mid-run is ignored so the running clock
  // never drops below the legal half-period.
  assign reload_ok  = divider_i >= DIVIDER_WIDTH'(MIN_DIV);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q     <= '0;
      cnt       <= '0;
      pdm_clk_o <= 1'b0;
    end else if (load_i) begin
      div_q     <= divider_i;
      cnt       <= '0;
      pdm_clk_o <= 1'b0;
    end else if (!run_i) begin
      cnt       <= '0;
      pdm_clk_o <= 1'b0;
    end else if (wrap) begin
      cnt       <= '0;
      pdm_clk_o <= !pdm_clk_o;
      if (!pdm_clk_o && reload_ok) begin
        div_q <= divider_i;
      end
    end else begin
      cnt <= cnt + DIVIDER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - multi-stage flip-flop synchronizer for a single async bit
//
// Purpose: brings an asynchronous level into the clk_i domain.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset, clears the chain
//   d_i    asynchronous input
//   q_o    synchronized output (last stage)
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain[STAGES-1];

endmodule

// File: rtl/pdm_interface.sv
// rtl/pdm_interface.sv - PDM microphone clock generator and bit capture front end
//
// Purpose: drives the microphone clock, synchronizes the data line, and emits
// one-cycle bit strobes per channel (left at falling edges, right at rising
// edges in stereo). Stopping finishes the current period first.
// Ports:
//   clk_i, rst_i            system clock, synchronous active-high reset
//   enable_i                run/stop request
//   divider_i               half-period of pdm_clk_o in clk_i cycles
//   stereo_i                capture right channel too
//   pdm_data_i              asynchronous microphone data
//   pdm_clk_o               microphone clock
//   left_o / left_valid_o   left bit and its strobe
//   right_o / right_valid_o right bit and its strobe
//   busy_o                  FSM not idle
//   config_error_o          sticky: start requested with too small a divider
module pdm_interface
  import pdm_pkg::*;
#(
  parameter int DIVIDER_WIDTH = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [DIVIDER_WIDTH-1:0] divider_i,
  input  logic                     stereo_i,
  input  logic                     pdm_data_i,
  output logic                     pdm_clk_o,
  output logic                     left_o,
  output logic                     left_valid_o,
  output logic                     right_o,
  output logic                     right_valid_o,
  output logic                     busy_o,
  output logic                     config_error_o
);

  localparam int MIN_START = (SYNC_STAGES > MIN_DIVIDER) ? SYNC_STAGES : MIN_DIVIDER;

  pdm_state_t state;
  logic       sync_q;
  logic       stereo_q;
  logic       rise_evt;
  logic       fall_evt;
  logic       cnt_zero;
  logic       div_ok;
  logic       start;
  logic       run;

  assign div_ok = divider_i >= DIVIDER_WIDTH'(MIN_START);
  assign start  = (state == IDLE) && enable_i && div_ok;
  assign run    = (state != IDLE);
  assign busy_o = run;

  synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (pdm_data_i),
    .q_o  (sync_q)
  );

  pdm_clock_divider #(
    .DIVIDER_WIDTH(DIVIDER_WIDTH),
    .MIN_DIV      (MIN_START)
  ) u_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .run_i     (run),
    .load_i    (start),
    .divider_i (divider_i),
    .pdm_clk_o (pdm_clk_o),
    .rise_evt_o(rise_evt),
    .fall_evt_o(fall_evt),
    .cnt_zero_o(cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      stereo_q       <= 1'b0;
      left_o         <= 1'b0;
      left_valid_o   <= 1'b0;
      right_o        <= 1'b0;
      right_valid_o  <= 1'b0;
      config_error_o <= 1'b0;
    end else begin
      left_valid_o  <= 1'b0;
      right_valid_o <= 1'b0;

      if (fall_evt) begin
        left_o       <= sync_q;
        left_valid_o <= 1'b1;
      end

      // stereo_q used for this capture is the value from the period just ended.
      if (rise_evt) begin
        if (stereo_q) begin
          right_o       <= sync_q;
          right_valid_o <= 1'b1;
        end
        stereo_q <= stereo_i;
      end

      unique case (state)
        IDLE: begin
          if (enable_i) begin
            if (div_ok) begin
              stereo_q       <= stereo_i;
              config_error_o <= 1'b0;
              state          <= RUN;
            end else begin
              config_error_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!enable_i) begin
            // Low at the very start of a period means nothing is in flight.
            if (fall_evt || (!pdm_clk_o && cnt_zero)) begin
              state <= IDLE;
            end else begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (fall_evt) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_interface.sv
// tb/tb_pdm_interface.sv - self-checking bench for pdm_interface
module tb_pdm_interface;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] divider = '0;
  logic         stereo = 1'b0;
  logic         pdm_data = 1'b1;
  logic         pdm_clk_o, left_o, left_valid_o, right_o, right_valid_o, busy_o, config_error_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pdm_interface #(
    .DIVIDER_WIDTH(W),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .divider_i     (divider),
    .stereo_i      (stereo),
    .pdm_data_i    (pdm_data),
    .pdm_clk_o     (pdm_clk_o),
    .left_o        (left_o),
    .left_valid_o  (left_valid_o),
    .right_o       (right_o),
    .right_valid_o (right_valid_o),
    .busy_o        (busy_o),
    .config_error_o(config_error_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Microphone: holds one bit per clock phase, changes it just after each
  // pdm_clk_o edge. Mode 0: always 1. Mode 1: 1 while high, 0 while low.
  // Mode 2: random bit per phase.
  int   mic_mode = 0;
  int   mic_last = 0;
  logic hi_bit = 1'b1, lo_bit = 1'b1, mic_prev = 1'b0;

  always @(negedge clk) begin
    if (mic_mode != mic_last) begin
      hi_bit   = 1'b1;
      lo_bit   = (mic_mode == 1) ? 1'b0 : 1'b1;
      mic_last = mic_mode;
    end else begin
      if (pdm_clk_o === 1'b1 && !mic_prev)
        hi_bit = (mic_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pdm_clk_o === 1'b0 && mic_prev)
        lo_bit = (mic_mode == 2) ? 1'($urandom_range(0, 1)) : ((mic_mode == 1) ? 1'b0 : 1'b1);
    end
    mic_prev = (pdm_clk_o === 1'b1);
    pdm_data = mic_prev ? hi_bit : lo_bit;
  end

  // Reference model: phase-based. A session is a sequence of half periods of
  // m_div edges each; left bit at the end of each high phase, right bit at
  // the end of each low phase when stereo; new config taken at rising edges.
  bit   m_init = 0, m_active = 0, m_stopping = 0, m_level = 0, m_st = 0, m_err = 0;
  int   m_remain = 0, m_div = 0;
  logic exp_clk = 0, exp_busy = 0, exp_err = 0, exp_lv = 0, exp_rv = 0, exp_left = 0, exp_right = 0;

  always @(posedge clk) begin
    exp_lv = 1'b0;
    exp_rv = 1'b0;
    if (rst) begin
      m_init = 1; m_active = 0; m_stopping = 0; m_level = 0; m_err = 0;
    end else if (m_init) begin
      if (!m_active) begin
        if (enable) begin
          if (int'(divider) >= 2) begin
            m_active = 1; m_stopping = 0; m_div = int'(divider); m_st = stereo;
            m_level = 0; m_remain = m_div; m_err = 0;
          end else begin
            m_err = 1;
          end
        end
      end else if (!m_stopping && !enable && !m_level && m_remain == m_div) begin
        m_active = 0;
      end else begin
        if (!enable) m_stopping = 1;
        m_remain = m_remain - 1;
        if (m_remain == 0) begin
          if (m_level) begin
            exp_lv = 1'b1; exp_left = hi_bit;
            m_level = 0; m_remain = m_div;
            if (m_stopping) m_active = 0;
          end else begin
            if (m_st) begin exp_rv = 1'b1; exp_right = lo_bit; end
            if (int'(divider) >= 2) m_div = int'(divider);
            m_st = stereo; m_level = 1; m_remain = m_div;
          end
        end
      end
    end
    exp_clk  = m_active && m_level;
    exp_busy = m_active;
    exp_err  = m_err;
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("pdm_clk_o", pdm_clk_o, exp_clk);
      check("busy_o", busy_o, exp_busy);
      check("config_error_o", config_error_o, exp_err);
      check("left_valid_o", left_valid_o, exp_lv);
      check("right_valid_o", right_valid_o, exp_rv);
      if (exp_lv) check("left_o", left_o, exp_left);
      if (exp_rv) check("right_o", right_o, exp_right);
    end
  end

  task automatic wait_clk(input logic v, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pdm_clk_o !== v && n < 2000);
    if (pdm_clk_o !== v) check("wait_clk timeout", pdm_clk_o, v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("return to idle", busy_o, 0);
  endtask

  initial begin
    int a, b, c, d, n, len;
    repeat (4) @(negedge clk);
    check("reset pdm_clk_o", pdm_clk_o, 0);
    check("reset busy_o", busy_o, 0);
    check("reset strobes", {left_valid_o, right_valid_o, left_o, right_o, config_error_o}, 0);
    rst = 1'b0;

    // Basic mono capture, divider 32, constant 1 data.
    mic_mode = 0; divider = 32; stereo = 0; enable = 1;
    repeat (32) @(negedge clk);
    check("t1 low before first rise", pdm_clk_o, 0);
    @(negedge clk);
    check("t1 first rise at 32", pdm_clk_o, 1);
    repeat (31) @(negedge clk);
    check("t1 no left strobe at 63", left_valid_o, 0);
    @(negedge clk);
    check("t1 left strobe at 64", left_valid_o, 1);
    check("t1 left bit", left_o, 1);
    wait_clk(1, b); wait_clk(0, a); wait_clk(1, c);
    check("t1 low phase", b, 32);
    check("t1 period", a + c, 64);
    enable = 0; wait_idle();

    // Stereo alternation, divider 16.
    mic_mode = 1; divider = 16; stereo = 1; enable = 1;
    wait_clk(1, n);
    check("t2 first rise", n, 17);
    for (int i = 0; i < 3; i++) begin
      check("t2 right strobe at rise", right_valid_o, 1);
      check("t2 right bit", right_o, 0);
      wait_clk(0, a);
      check("t2 left 16 after right", a, 16);
      check("t2 left strobe at fall", left_valid_o, 1);
      check("t2 left bit", left_o, 1);
      wait_clk(1, b);
    end
    enable = 0; wait_idle();

    // Divider change 32 -> 8 during the high phase.
    mic_mode = 2; stereo = 0; divider = 32; enable = 1;
    wait_clk(1, n);
    repeat (10) @(negedge clk);
    divider = 8;
    wait_clk(0, a); wait_clk(1, b); wait_clk(0, c); wait_clk(1, d);
    check("t3 rest of high", a, 22);
    check("t3 old low", b, 32);
    check("t3 new period", c + d, 16);
    enable = 0; wait_idle();

    // Graceful stop, divider 10, enable dropped 5 cycles after a rise.
    divider = 10; enable = 1;
    wait_clk(1, n);
    repeat (4) @(negedge clk);
    enable = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (left_valid_o !== 1'b1 && n < 100);
    check("t4 final capture delay", n, 6);
    check("t4 clock low after stop", pdm_clk_o, 0);
    check("t4 busy low after stop", busy_o, 0);
    repeat (20) @(negedge clk);
    check("t4 clock stays low", pdm_clk_o, 0);

    // Invalid divider, then valid restart.
    divider = 1; enable = 1;
    repeat (5) @(negedge clk);
    check("t5 config error set", config_error_o, 1);
    check("t5 clock idle", pdm_clk_o, 0);
    check("t5 not busy", busy_o, 0);
    divider = 4;
    @(negedge clk);
    check("t5 config error cleared", config_error_o, 0);
    check("t5 running", busy_o, 1);
    repeat (60) @(negedge clk);
    enable = 0; wait_idle();

    // Reset during the high phase, then restart.
    divider = 20; enable = 1;
    wait_clk(1, n);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t6 outputs cleared", {pdm_clk_o, busy_o, left_valid_o, right_valid_o, config_error_o}, 0);
    wait_clk(1, n);
    check("t6 first rise after restart", n, 21);
    enable = 0; wait_idle();

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      divider = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 1)) : W'($urandom_range(3, 12));
      stereo  = 1'($urandom_range(0, 1));
      enable  = 1;
      len = $urandom_range(10, 150);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if ($urandom_range(0, 19) == 0) divider = W'($urandom_range(3, 12));
        if ($urandom_range(0, 19) == 0) stereo = ~stereo;
      end
      enable = 0;
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk); enable = 1;
        @(negedge clk); enable = 0;
      end
      wait_idle();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
